// File: rtl/seg_scroller.sv
// Scrolls one of four 16-character 7-segment messages across eight digits, one step per SCROLL_DIV clocks.
// Outputs registered (display lags pos by one cycle); a sel change restarts the message.
module seg_scroller #(
   parameter int unsigned SCROLL_DIV = 25000000,
   parameter int unsigned MSG_LEN    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  sel,
   input  logic        pause,
   output logic [55:0] digit_segs,
   output logic        wrap
);

   localparam int PW = $clog2(MSG_LEN);
   localparam logic [31:0]   DIV_LAST = 32'(SCROLL_DIV - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
   localparam logic [55:0]   BLANK    = '1;

   // Active-low patterns, bit 6 = g .. bit 0 = a; 7'h7F is a blank digit.
   localparam logic [0:15][6:0] MSG0 = '{7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F,
                                         7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
   localparam logic [0:15][6:0] MSG1 = '{7'h12, 7'h46, 7'h2F, 7'h40, 7'h47, 7'h47, 7'h7F, 7'h7F,
                                         7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
   localparam logic [0:15][6:0] MSG2 = '{7'h21, 7'h06, 7'h08, 7'h21, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                                         7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
   localparam logic [0:15][6:0] MSG3 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef enum logic [1:0] {RESTART, RUN, PAUSED} state_t;

   state_t        state_q;
   logic [PW-1:0] pos_q;
   logic [31:0]   div_cnt_q;
   logic [1:0]    sel_q;
   logic [55:0]   segs_q, segs_d;
   logic          wrap_q;
   logic          step_d;
   logic          sel_chg_d;

   function automatic logic [6:0] char_at(input logic [1:0] m, input logic [PW-1:0] p);
      case (m)
         2'd0:    return MSG0[p];
         2'd1:    return MSG1[p];
         2'd2:    return MSG2[p];
         default: return MSG3[p];
      endcase
   endfunction

   // Digit 7 (leftmost) shows the character at pos, digit 0 the one seven places on.
   always_comb begin
      segs_d = BLANK;
      for (int i = 0; i < 8; i++) begin
         segs_d[7*i +: 7] = char_at(sel_q, pos_q + PW'(7 - i));
      end
   end

   assign step_d    = (div_cnt_q == DIV_LAST);
   assign sel_chg_d = (sel != sel_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RESTART;
         pos_q     <= '0;
         div_cnt_q <= '0;
         sel_q     <= sel;
         segs_q    <= BLANK;
         wrap_q    <= 1'b0;
      end else begin
         case (state_q)
            RESTART: begin
               pos_q     <= '0;
               div_cnt_q <= '0;
               sel_q     <= sel;
               segs_q    <= BLANK;
               wrap_q    <= 1'b0;
               state_q   <= RUN;
            end
            RUN: begin
               segs_q <= segs_d;
               wrap_q <= 1'b0;
               if (sel_chg_d) begin
                  state_q <= RESTART;
               end else begin
                  if (step_d) begin
                     div_cnt_q <= '0;
                     pos_q     <= pos_q + PW'(1);
                     wrap_q    <= (pos_q == POS_LAST);
                  end else begin
                     div_cnt_q <= div_cnt_q + 32'd1;
                  end
                  if (pause) state_q <= PAUSED;
               end
            end
            PAUSED: begin
               segs_q <= segs_d;
               wrap_q <= 1'b0;
               if (sel_chg_d)  state_q <= RESTART;
               else if (!pause) state_q <= RUN;
            end
            default: state_q <= RESTART;
         endcase
      end
   end

   assign digit_segs = segs_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_seg_scroller.sv
// Directed bench for seg_scroller with SCROLL_DIV=4: vector table plus multi-cycle sequences.
module tb_seg_scroller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  sel = 2'd3;
   logic        pause = 1'b0;
   logic [55:0] digit_segs;
   logic        wrap;

   int total = 0;
   int bad   = 0;

   localparam logic [55:0] ONES = {56{1'b1}};

   logic [6:0] tb_msg [4][16] = '{
      '{7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
      '{7'h12, 7'h46, 7'h2F, 7'h40, 7'h47, 7'h47, 7'h7F, 7'h7F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
      '{7'h21, 7'h06, 7'h08, 7'h21, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
      '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}};

   seg_scroller #(.SCROLL_DIV(4), .MSG_LEN(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .sel        (sel),
      .pause      (pause),
      .digit_segs (digit_segs),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] win(input int m, input int p);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[7*i +: 7] = tb_msg[m][(p + 7 - i) % 16];
      return r;
   endfunction

   task automatic tick(input logic r, input logic [1:0] s, input logic p);
      reset = r;
      sel   = s;
      pause = p;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [55:0] got, input logic [55:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic restart_run(input logic [1:0] s);
      tick(1'b1, s, 1'b0);
      tick(1'b1, s, 1'b0);
      tick(1'b0, s, 1'b0);
   endtask

   typedef struct {
      string       name;
      logic        rst;
      logic [1:0]  sel;
      logic        pause;
      int          n;
      logic [55:0] exp_segs;
      logic        exp_wrap;
   } vec_t;

   vec_t vt [12];
   int   nwrap;

   initial begin
      vt[0]  = '{"rst_hold",     1'b1, 2'd3, 1'b0, 2, ONES,      1'b0};
      vt[1]  = '{"restart_cyc",  1'b0, 2'd3, 1'b0, 1, ONES,      1'b0};
      vt[2]  = '{"first_char",   1'b0, 2'd3, 1'b0, 1, win(3, 0), 1'b0};
      vt[3]  = '{"stable_pos0",  1'b0, 2'd3, 1'b0, 3, win(3, 0), 1'b0};
      vt[4]  = '{"step1",        1'b0, 2'd3, 1'b0, 1, win(3, 1), 1'b0};
      vt[5]  = '{"stable_pos1",  1'b0, 2'd3, 1'b0, 3, win(3, 1), 1'b0};
      vt[6]  = '{"step2",        1'b0, 2'd3, 1'b0, 1, win(3, 2), 1'b0};
      vt[7]  = '{"rst_sel1",     1'b1, 2'd1, 1'b0, 1, ONES,      1'b0};
      vt[8]  = '{"restart_sel1", 1'b0, 2'd1, 1'b0, 1, ONES,      1'b0};
      vt[9]  = '{"msg1_pos0",    1'b0, 2'd1, 1'b0, 3, win(1, 0), 1'b0};
      vt[10] = '{"rst_sel2",     1'b1, 2'd2, 1'b0, 2, ONES,      1'b0};
      vt[11] = '{"msg2_pos0",    1'b0, 2'd2, 1'b0, 1, ONES,      1'b0};

      for (int v = 0; v < 12; v++) begin
         for (int c = 0; c < vt[v].n; c++) begin
            tick(vt[v].rst, vt[v].sel, vt[v].pause);
            chk({vt[v].name, "_segs"}, digit_segs, vt[v].exp_segs);
            chk({vt[v].name, "_wrap"}, {55'd0, wrap}, {55'd0, vt[v].exp_wrap});
         end
      end
      tick(1'b0, 2'd2, 1'b0);
      chk("msg2_first", digit_segs, win(2, 0));

      // Full revolution: pos reaches 15->0 at edge 65 after the restart edge.
      restart_run(2'd3);
      nwrap = 0;
      for (int k = 2; k <= 72; k++) begin
         tick(1'b0, 2'd3, 1'b0);
         if (wrap === 1'b1) nwrap++;
         chk("wrap_seq", {55'd0, wrap}, {55'd0, (k == 65)});
         if (k == 2) begin
            chk("d7_is_0", {49'd0, digit_segs[55:49]}, {49'd0, 7'b1000000});
            chk("d0_is_7", {49'd0, digit_segs[6:0]},   {49'd0, 7'b1111000});
         end
         if (k == 6) begin
            chk("d7_is_1", {49'd0, digit_segs[55:49]}, {49'd0, 7'b1111001});
            chk("d0_is_8", {49'd0, digit_segs[6:0]},   {49'd0, 7'b0000000});
         end
         if (k == 65) chk("pos15_at_wrap", digit_segs, win(3, 15));
         if (k == 66) chk("d7_back_to_0", {49'd0, digit_segs[55:49]}, {49'd0, 7'b1000000});
      end
      chk("wrap_count", 56'(nwrap), 56'd1);

      // Pause asserted while div_cnt=2, held 10 cycles; resume keeps the step phase.
      restart_run(2'd3);
      tick(1'b0, 2'd3, 1'b0);
      tick(1'b0, 2'd3, 1'b0);
      for (int k = 4; k <= 13; k++) begin
         tick(1'b0, 2'd3, 1'b1);
         chk("pause_frozen", digit_segs, win(3, 0));
         chk("pause_nowrap", {55'd0, wrap}, 56'd0);
      end
      tick(1'b0, 2'd3, 1'b0);
      chk("resume_e14", digit_segs, win(3, 0));
      tick(1'b0, 2'd3, 1'b0);
      chk("resume_e15", digit_segs, win(3, 0));
      tick(1'b0, 2'd3, 1'b0);
      chk("resume_step", digit_segs, win(3, 1));
      tick(1'b0, 2'd3, 1'b0);
      tick(1'b0, 2'd3, 1'b0);
      // Pause landing on a step edge still lets that step happen.
      tick(1'b0, 2'd3, 1'b1);
      chk("pause_on_step_a", digit_segs, win(3, 1));
      tick(1'b0, 2'd3, 1'b1);
      chk("pause_on_step_b", digit_segs, win(3, 2));
      tick(1'b0, 2'd3, 1'b1);
      tick(1'b0, 2'd3, 1'b1);
      chk("pause_on_step_hold", digit_segs, win(3, 2));

      // sel 3->0 on a step edge: restart wins, one blank cycle, message 0 from pos 0.
      restart_run(2'd3);
      for (int k = 2; k <= 4; k++) tick(1'b0, 2'd3, 1'b0);
      tick(1'b0, 2'd0, 1'b0);
      chk("selchg_no_step", digit_segs, win(3, 0));
      tick(1'b0, 2'd0, 1'b0);
      chk("selchg_blank", digit_segs, ONES);
      for (int k = 7; k <= 10; k++) begin
         tick(1'b0, 2'd0, 1'b0);
         chk("selchg_msg0_pos0", digit_segs, win(0, 0));
         chk("selchg_nowrap", {55'd0, wrap}, 56'd0);
      end
      tick(1'b0, 2'd0, 1'b0);
      chk("selchg_msg0_pos1", digit_segs, win(0, 1));

      // Reset while paused at pos 9 abandons the position with no wrap pulse.
      restart_run(2'd3);
      for (int k = 2; k <= 38; k++) tick(1'b0, 2'd3, 1'b0);
      chk("pos9_shown", digit_segs, win(3, 9));
      for (int k = 39; k <= 42; k++) begin
         tick(1'b0, 2'd3, 1'b1);
         chk("pos9_paused", digit_segs, win(3, 9));
      end
      tick(1'b1, 2'd3, 1'b1);
      chk("rst_paused_blank", digit_segs, ONES);
      chk("rst_paused_wrap", {55'd0, wrap}, 56'd0);
      tick(1'b0, 2'd3, 1'b0);
      chk("rst_paused_restart", digit_segs, ONES);
      tick(1'b0, 2'd3, 1'b0);
      chk("rst_paused_pos0", digit_segs, win(3, 0));
      nwrap = 0;
      for (int k = 46; k <= 60; k++) begin
         tick(1'b0, 2'd3, 1'b0);
         if (wrap === 1'b1) nwrap++;
      end
      chk("rst_paused_nowrap", 56'(nwrap), 56'd0);
      chk("rst_paused_later", digit_segs, win(3, 3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
